data_memory_sized: RTL and testbench

- Parametrised byte-addressed data memory for the CPU's MEM stage.
- Supports byte, halfword and word loads and stores, little-endian, with signed or unsigned load extension.
- Configurable wait-state latency with a req/ready/done handshake, so the pipeline can stall on it.
- Detects misaligned and out-of-range accesses and reports them as errors instead of corrupting memory.

---
 rtl/data_mem_pkg.sv | 24 ++
 rtl/load_extend.sv | 21 ++
 rtl/data_memory_sized.sv | 172 +++++++++++++++++
 tb/tb_data_memory_sized.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings, FSM states and helpers for the byte-addressed data memory.
package data_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Number of bytes touched by an access; 0 marks the illegal size encoding.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_nbytes = 3'd1;
      SIZE_H:  size_nbytes = 3'd2;
      SIZE_W:  size_nbytes = 3'd4;
      default: size_nbytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Formats raw little-endian read bytes into a 32-bit load result.
module load_extend
  import data_mem_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  // Select width and apply zero or sign extension.
  always_comb begin
    data_o = raw_i;
    case (size_i)
      SIZE_B:  data_o = {{24{~unsigned_i & raw_i[7]}}, raw_i[7:0]};
      SIZE_H:  data_o = {{16{~unsigned_i & raw_i[15]}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with wait states, alignment/range checking and
// a req/ready/done handshake for the MEM stage.
module data_memory_sized
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 32,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       data_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_BYTES);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            done_q;
  logic            err_q;

  logic [7:0]      mem_q [DEPTH_BYTES];

  logic            accept;
  logic            req_err;
  logic [ADDR_W:0] end_addr;
  logic            go_direct;
  logic            go_wait;
  logic            access;
  logic            op_we;
  logic [1:0]      op_size;
  logic            op_uns;
  logic [IdxW-1:0] op_idx;
  logic [31:0]     op_wdata;
  logic [2:0]      op_nbytes;
  logic [31:0]     raw;
  logic [31:0]     ext;

  assign ready_o = (state_q == IDLE) & ~rst_i;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign data_o  = rdata_q;

  assign accept  = req_i & ready_o;

  // Request legality, judged on the full address so high bits never wrap.
  always_comb begin
    end_addr = {1'b0, addr_i} + (ADDR_W + 1)'(size_nbytes(size_i));
    req_err  = (size_i == 2'b11)
             | ((size_i == SIZE_H) & addr_i[0])
             | ((size_i == SIZE_W) & (|addr_i[1:0]))
             | (end_addr > (ADDR_W + 1)'(DEPTH_BYTES));
  end

  // The access happens on the edge entering RESP: straight from IDLE when
  // LATENCY is 1 (operands still on the inputs), else from the last WAIT edge.
  always_comb begin
    go_direct = accept & ~req_err & (LATENCY == 1);
    go_wait   = (state_q == WAIT) & (cnt_q == 4'd0);
    access    = go_direct | go_wait;
    if (state_q == IDLE) begin
      op_we    = we_i;
      op_size  = size_i;
      op_uns   = unsigned_i;
      op_idx   = addr_i[IdxW-1:0];
      op_wdata = data_i;
    end else begin
      op_we    = we_q;
      op_size  = size_q;
      op_uns   = uns_q;
      op_idx   = idx_q;
      op_wdata = wdata_q;
    end
    op_nbytes = size_nbytes(op_size);
  end

  // Gather four consecutive bytes; only the low nbytes matter for the result.
  always_comb begin
    raw = '0;
    for (int k = 0; k < 4; k++) begin
      raw[8*k +: 8] = mem_q[op_idx + IdxW'(k)];
    end
  end

  load_extend u_load_extend (
    .raw_i      (raw),
    .size_i     (op_size),
    .unsigned_i (op_uns),
    .data_o     (ext)
  );

  // Byte array write; not reset, and suppressed while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (access && op_we && !rst_i) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < op_nbytes) begin
          mem_q[op_idx + IdxW'(k)] <= op_wdata[8*k +: 8];
        end
      end
    end
  end

  // Control FSM with registered done/err/data outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            idx_q   <= addr_i[IdxW-1:0];
            wdata_q <= data_i;
            if (req_err) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (LATENCY == 1) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              if (!we_i) rdata_q <= ext;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            if (!we_q) rdata_q <= ext;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: one LATENCY=1 and one LATENCY=4 instance,
// expected responses queued at drive time and compared when done_o pulses.
module tb_data_memory_sized;
  import data_mem_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, req1, we1, uns1, ready1, done1, err1;
  logic [1:0]  size1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        rst4, req4, we4, uns4, ready4, done4, err4;
  logic [1:0]  size4;
  logic [31:0] addr4, wdata4, rdata4;

  exp_t q1[$];
  exp_t q4[$];
  int   checks   = 0;
  int   failures = 0;

  data_memory_sized #(.DEPTH_BYTES(32), .LATENCY(1), .ADDR_W(32)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .req_i(req1), .we_i(we1), .size_i(size1),
    .unsigned_i(uns1), .addr_i(addr1), .data_i(wdata1), .ready_o(ready1),
    .done_o(done1), .err_o(err1), .data_o(rdata1)
  );

  data_memory_sized #(.DEPTH_BYTES(32), .LATENCY(4), .ADDR_W(32)) u_dut4 (
    .clk_i(clk), .rst_i(rst4), .req_i(req4), .we_i(we4), .size_i(size4),
    .unsigned_i(uns4), .addr_i(addr4), .data_i(wdata4), .ready_o(ready4),
    .done_o(done4), .err_o(err4), .data_o(rdata4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete request: queue the expectation, drive, wait (bounded) for done.
  task automatic op(input bit s4, input bit we, input logic [1:0] sz, input bit uns,
                    input logic [31:0] addr, input logic [31:0] wd, input bit xerr,
                    input logic [31:0] xdata, input int xlat, input string tag);
    exp_t e;
    int   lat;
    e.err  = xerr;
    e.data = xdata;
    if (s4) q4.push_back(e); else q1.push_back(e);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(s4 ? ready4 : ready1), 32'd1);
    if (s4) begin
      req4 = 1'b1; we4 = we; size4 = sz; uns4 = uns; addr4 = addr; wdata4 = wd;
    end else begin
      req1 = 1'b1; we1 = we; size1 = sz; uns1 = uns; addr1 = addr; wdata1 = wd;
    end
    @(negedge clk);
    req1 = 1'b0;
    req4 = 1'b0;
    lat  = 1;
    while (!(s4 ? done4 : done1) && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(xlat));
    chk({tag, "_done"}, 32'(s4 ? done4 : done1), 32'd1);
    e = s4 ? q4.pop_front() : q1.pop_front();
    chk({tag, "_err"}, 32'(s4 ? err4 : err1), 32'(e.err));
    chk({tag, "_data"}, s4 ? rdata4 : rdata1, e.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    rst1 = 1'b1; req1 = 1'b0; we1 = 1'b0; size1 = SIZE_W; uns1 = 1'b0;
    addr1 = '0; wdata1 = '0;
    rst4 = 1'b1; req4 = 1'b0; we4 = 1'b0; size4 = SIZE_W; uns4 = 1'b0;
    addr4 = '0; wdata4 = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ready1", 32'(ready1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
    chk("rst_data1", rdata1, 32'd0);
    chk("rst_ready4", 32'(ready4), 32'd0);
    rst1 = 1'b0;
    rst4 = 1'b0;
    #1;
    chk("post_rst_ready1", 32'(ready1), 32'd1);

    // LATENCY=1 functional sequence
    op(0, 1, SIZE_W, 0, 32'd4,  32'h8081_7F01, 0, 32'h0000_0000, 1, "sw4");
    op(0, 0, SIZE_W, 0, 32'd4,  '0, 0, 32'h8081_7F01, 1, "lw4");
    op(0, 0, SIZE_B, 0, 32'd6,  '0, 0, 32'hFFFF_FF81, 1, "lb6");
    op(0, 0, SIZE_B, 1, 32'd6,  '0, 0, 32'h0000_0081, 1, "lbu6");
    op(0, 0, SIZE_H, 0, 32'd4,  '0, 0, 32'h0000_7F01, 1, "lh4");
    op(0, 0, SIZE_H, 1, 32'd6,  '0, 0, 32'h0000_8081, 1, "lhu6");
    op(0, 0, SIZE_H, 0, 32'd6,  '0, 0, 32'hFFFF_8081, 1, "lh6");
    op(0, 1, SIZE_B, 0, 32'd5,  32'h0000_00AA, 0, 32'hFFFF_8081, 1, "sb5");
    op(0, 0, SIZE_W, 0, 32'd4,  '0, 0, 32'h8081_AA01, 1, "lw4_after_sb");
    op(0, 0, SIZE_W, 0, 32'd2,  '0, 1, 32'h0000_0000, 1, "lw2_misal");
    op(0, 1, SIZE_W, 0, 32'd28, 32'h1234_5678, 0, 32'h0000_0000, 1, "sw28");
    op(0, 1, SIZE_H, 0, 32'd31, 32'h0000_BEEF, 1, 32'h0000_0000, 1, "sh31_err");
    op(0, 0, SIZE_W, 0, 32'd28, '0, 0, 32'h1234_5678, 1, "lw28");
    op(0, 0, SIZE_W, 0, 32'd32, '0, 1, 32'h0000_0000, 1, "lw32_range");
    op(0, 0, SIZE_W, 0, 32'd28, '0, 0, 32'h1234_5678, 1, "lw28_again");
    op(0, 0, 2'b11,  0, 32'd0,  '0, 1, 32'h0000_0000, 1, "size11");
    op(0, 0, SIZE_W, 0, 32'h100, '0, 1, 32'h0000_0000, 1, "lw_highbits");

    // LATENCY=4: seed a word, then check exact handshake timing
    op(1, 1, SIZE_W, 0, 32'd8, 32'h1122_3344, 0, 32'h0000_0000, 4, "l4_sw8");
    e.err = 1'b0;
    e.data = 32'h1122_3344;
    q4.push_back(e);
    q4.push_back(e);
    @(negedge clk);
    req4 = 1'b1; we4 = 1'b0; size4 = SIZE_W; uns4 = 1'b0; addr4 = 32'd8;
    @(posedge clk);  // edge 0: accepted
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("l4_ready_c%0d", c), 32'(ready4), 32'd0);
      chk($sformatf("l4_done_c%0d", c), 32'(done4), 32'(c == 4));
      if (c == 4) begin
        e = q4.pop_front();
        chk("l4_first_err", 32'(err4), 32'(e.err));
        chk("l4_first_data", rdata4, e.data);
      end
    end
    @(negedge clk);  // cycle 5
    chk("l4_ready_c5", 32'(ready4), 32'd1);
    @(negedge clk);  // cycle 6: held request taken at edge 5
    chk("l4_ready_c6", 32'(ready4), 32'd0);
    req4 = 1'b0;
    n = 6;
    while (!done4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("l4_second_done_cycle", 32'(n), 32'd9);
    e = q4.pop_front();
    chk("l4_second_err", 32'(err4), 32'(e.err));
    chk("l4_second_data", rdata4, e.data);

    // Reset during WAIT of a store must abandon it without writing
    @(negedge clk);
    req4 = 1'b1; we4 = 1'b1; size4 = SIZE_W; addr4 = 32'd8; wdata4 = 32'hDEAD_BEEF;
    @(negedge clk);
    req4 = 1'b0;
    rst4 = 1'b1;
    #1;
    chk("midrst_ready_a", 32'(ready4), 32'd0);
    @(negedge clk);
    chk("midrst_ready_b", 32'(ready4), 32'd0);
    chk("midrst_done_b", 32'(done4), 32'd0);
    rst4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_done_%0d", c), 32'(done4), 32'd0);
    end
    op(1, 0, SIZE_W, 0, 32'd8, '0, 0, 32'h1122_3344, 4, "l4_lw8_after_rst");

    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q4_empty", 32'(q4.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
